// File: rtl/i2c_target_responder_if.sv
// Register-port bundle between the I2C target and its register file.
interface i2c_target_responder_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/i2c_target_responder.sv
// I2C target: START/STOP decode, 7-bit address match, register bridge with
// an auto-incrementing pointer. Open-drain SDA, no clock stretching.
module i2c_target_responder #(
  parameter logic [6:0]  ADDR       = 7'h3E,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   SCL_PIN,
  inout  wire                    SDA_PIN,
  i2c_target_responder_if.master reg_if,
  output logic                   busy
);
  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_e;

  logic             scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_f_q, scl_f_d, scl_p_q, scl_p_d;
  logic             sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_f_q, sda_f_d, sda_p_q, sda_p_d;
  logic [CNT_W-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       sh_q, sh_d, ptr_q, ptr_d;
  logic             rw_q, rw_d, mack_q, mack_d, fetch_q, fetch_d, sda_oe_q, sda_oe_d;
  logic [7:0]       reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
  logic             reg_we_q, reg_we_d, reg_re_q, reg_re_d, busy_q, busy_d;

  logic scl_rise_c, scl_fall_c, start_c, stop_c;

  assign scl_rise_c = scl_f_q & ~scl_p_q;
  assign scl_fall_c = ~scl_f_q & scl_p_q;
  assign start_c    = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_c     = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

  assign SDA_PIN          = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_if.reg_addr  = reg_addr_q;
  assign reg_if.reg_wdata = reg_wdata_q;
  assign reg_if.reg_we    = reg_we_q;
  assign reg_if.reg_re    = reg_re_q;
  assign busy             = busy_q;

  // All state registers, synchronous reset; bus lines idle high.
  always_ff @(posedge CLK) begin
    if (reset) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_f_q <= 1'b1; scl_p_q <= 1'b1; scl_cnt_q <= '0;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_f_q <= 1'b1; sda_p_q <= 1'b1; sda_cnt_q <= '0;
      state_q <= S_IDLE; bit_cnt_q <= 4'd0; sh_q <= 8'h00; ptr_q <= 8'h00;
      rw_q <= 1'b0; mack_q <= 1'b0; fetch_q <= 1'b0; sda_oe_q <= 1'b0;
      reg_addr_q <= 8'h00; reg_wdata_q <= 8'h00; reg_we_q <= 1'b0; reg_re_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      scl_s1_q <= scl_s1_d; scl_s2_q <= scl_s2_d; scl_f_q <= scl_f_d; scl_p_q <= scl_p_d;
      scl_cnt_q <= scl_cnt_d;
      sda_s1_q <= sda_s1_d; sda_s2_q <= sda_s2_d; sda_f_q <= sda_f_d; sda_p_q <= sda_p_d;
      sda_cnt_q <= sda_cnt_d;
      state_q <= state_d; bit_cnt_q <= bit_cnt_d; sh_q <= sh_d; ptr_q <= ptr_d;
      rw_q <= rw_d; mack_q <= mack_d; fetch_q <= fetch_d; sda_oe_q <= sda_oe_d;
      reg_addr_q <= reg_addr_d; reg_wdata_q <= reg_wdata_d;
      reg_we_q <= reg_we_d; reg_re_q <= reg_re_d; busy_q <= busy_d;
    end
  end

  // Synchronize both lines, then only accept a new level once it has held FILTER_LEN cycles.
  always_comb begin
    scl_s1_d = SCL_PIN;  scl_s2_d = scl_s1_q; scl_f_d = scl_f_q; scl_p_d = scl_f_q; scl_cnt_d = '0;
    sda_s1_d = SDA_PIN;  sda_s2_d = sda_s1_q; sda_f_d = sda_f_q; sda_p_d = sda_f_q; sda_cnt_d = '0;
    if (scl_s2_q != scl_f_q) begin
      if (scl_cnt_q == CNT_MAX) scl_f_d = scl_s2_q;
      else                      scl_cnt_d = scl_cnt_q + 1'b1;
    end
    if (sda_s2_q != sda_f_q) begin
      if (sda_cnt_q == CNT_MAX) sda_f_d = sda_s2_q;
      else                      sda_cnt_d = sda_cnt_q + 1'b1;
    end
  end

  // Protocol FSM: bits sampled on SCL rise, SDA changed on SCL fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    fetch_d     = reg_re_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;

    // read data arrives one cycle after the strobe
    if (fetch_q) sh_d = reg_if.reg_rdata;

    if (stop_c) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_c) begin
      state_d   = S_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise_c && bit_cnt_q != 4'd8) begin
            sh_d      = {sh_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_c && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == S_ADDR) begin
              if (sh_q[7:1] == ADDR) begin
                state_d  = S_ADDR_ACK;
                rw_d     = sh_q[0];
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d = S_IGNORE;
                busy_d  = 1'b0;
              end
            end else if (state_q == S_PTR) begin
              ptr_d    = sh_q;
              state_d  = S_PTR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d  = S_WDATA_ACK;
              sda_oe_d = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise_c && rw_q) begin
            reg_re_d   = 1'b1;
            reg_addr_d = ptr_q;
          end else if (scl_fall_c) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d  = S_RDATA;
              sda_oe_d = ~sh_q[7];
            end else begin
              state_d  = S_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_PTR_ACK: begin
          if (scl_fall_c) begin
            state_d  = S_WDATA;
            sda_oe_d = 1'b0;
          end
        end
        S_WDATA_ACK: begin
          if (scl_rise_c) begin
            reg_we_d    = 1'b1;
            reg_addr_d  = ptr_q;
            reg_wdata_d = sh_q;
            ptr_d       = ptr_q + 8'd1;
          end else if (scl_fall_c) begin
            state_d  = S_WDATA;
            sda_oe_d = 1'b0;
          end
        end
        S_RDATA: begin
          if (scl_rise_c && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_c) begin
            if (bit_cnt_q == 4'd8) begin
              state_d  = S_RDATA_ACK;
              sda_oe_d = 1'b0;
            end else begin
              sh_d     = {sh_q[6:0], 1'b0};
              sda_oe_d = ~sh_q[6];
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise_c) begin
            ptr_d  = ptr_q + 8'd1;
            mack_d = ~sda_f_q;
            if (!sda_f_q) begin
              reg_re_d   = 1'b1;
              reg_addr_d = ptr_q + 8'd1;
            end
          end else if (scl_fall_c) begin
            bit_cnt_d = 4'd0;
            if (mack_q) begin
              state_d  = S_RDATA;
              sda_oe_d = ~sh_q[7];
            end else begin
              state_d  = S_IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_IDLE, S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench: bit-banged I2C master, register-file model, scoreboard of strobes.
module tb_i2c_target_responder;
  localparam int Q = 10;  // quarter SCL period in CLK cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic tb_low = 1'b0;
  logic busy;
  wire  sda_bus;

  assign sda_bus = tb_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_target_responder_if rif ();

  i2c_target_responder dut (
    .CLK     (clk),
    .reset   (rst),
    .SCL_PIN (scl),
    .SDA_PIN (sda_bus),
    .reg_if  (rif.master),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_we[$];
  logic [7:0]  exp_re[$];
  int we_pushed = 0, we_seen = 0, re_pushed = 0, re_seen = 0, both_cnt = 0;
  bit dut_low_seen = 1'b0, busy_seen = 1'b0;

  // register model: read data = address inverted, registered
  always @(posedge clk) if (rif.reg_re) rif.reg_rdata <= rif.reg_addr ^ 8'hFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop expected strobes as the DUT produces them
  always @(negedge clk) begin
    if (rif.reg_we && rif.reg_re) both_cnt++;
    if (rif.reg_we) begin
      we_seen++;
      if (exp_we.size() != 0) check("we_addr_data", 32'({rif.reg_addr, rif.reg_wdata}), 32'(exp_we.pop_front()));
    end
    if (rif.reg_re) begin
      re_seen++;
      if (exp_re.size() != 0) check("re_addr", 32'(rif.reg_addr), 32'(exp_re.pop_front()));
    end
    if (sda_bus === 1'b0 && !tb_low) dut_low_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clk_bit(input logic b, output logic s);
    wait_clk(Q); tb_low = !b;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); s = sda_bus;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic start_cond();
    if (scl == 1'b0) begin
      wait_clk(Q); tb_low = 1'b0;
      wait_clk(Q); scl = 1'b1;
    end
    wait_clk(Q); tb_low = 1'b1;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clk(Q); tb_low = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); tb_low = 1'b0;
    wait_clk(4 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clk_bit(nack, s);
  endtask

  task automatic push_we(input logic [7:0] a, input logic [7:0] d);
    exp_we.push_back({a, d});
    we_pushed++;
  endtask

  task automatic push_re(input logic [7:0] a);
    exp_re.push_back(a);
    re_pushed++;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_we_cnt"}, 32'(we_seen), 32'(we_pushed));
    check({tag, "_re_cnt"}, 32'(re_seen), 32'(re_pushed));
    check({tag, "_both"}, 32'(both_cnt), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  logic       a;
  logic [7:0] d;

  initial begin
    // reset state
    wait_clk(3);
    check("rst_sda", 32'(sda_bus), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we_re", 32'({rif.reg_we, rif.reg_re}), 32'd0);
    check("rst_addr_wdata", 32'({rif.reg_addr, rif.reg_wdata}), 32'd0);
    rst = 1'b0;
    wait_clk(20);

    // write two bytes from pointer 0x10
    push_we(8'h10, 8'hA5); push_we(8'h11, 8'h5A);
    start_cond();
    send_byte(8'h7C, a); check("w_ack_addr", 32'(a), 32'd0);
    send_byte(8'h10, a); check("w_ack_ptr", 32'(a), 32'd0);
    check("w_busy", 32'(busy), 32'd1);
    send_byte(8'hA5, a); check("w_ack_d0", 32'(a), 32'd0);
    send_byte(8'h5A, a); check("w_ack_d1", 32'(a), 32'd0);
    stop_cond();
    check_counts("write");

    // pointer left at 0x12: single-byte read
    push_re(8'h12);
    start_cond();
    send_byte(8'h7D, a); check("rp_ack", 32'(a), 32'd0);
    recv_byte(1'b1, d);  check("rp_byte", 32'(d), 32'hED);
    stop_cond();
    check_counts("rdptr");

    // pointer set, repeated start, two-byte read
    push_re(8'h20); push_re(8'h21);
    start_cond();
    send_byte(8'h7C, a); check("r_ack_addr", 32'(a), 32'd0);
    send_byte(8'h20, a); check("r_ack_ptr", 32'(a), 32'd0);
    start_cond();
    send_byte(8'h7D, a); check("r_ack_addr_rd", 32'(a), 32'd0);
    recv_byte(1'b0, d);  check("r_byte0", 32'(d), 32'hDF);
    recv_byte(1'b1, d);  check("r_byte1", 32'(d), 32'hDE);
    wait_clk(Q);
    check("r_release_after_nack", 32'(sda_bus), 32'd1);
    stop_cond();
    check_counts("read");

    // address mismatch
    dut_low_seen = 1'b0; busy_seen = 1'b0;
    start_cond();
    send_byte(8'h7E, a); check("mm_nack_addr", 32'(a), 32'd1);
    send_byte(8'h00, a); check("mm_nack_data", 32'(a), 32'd1);
    stop_cond();
    check("mm_no_drive", 32'(dut_low_seen), 32'd0);
    check("mm_no_busy", 32'(busy_seen), 32'd0);
    check_counts("mismatch");

    // pointer wrap
    push_we(8'hFF, 8'h01); push_we(8'h00, 8'h02);
    start_cond();
    send_byte(8'h7C, a);
    send_byte(8'hFF, a);
    send_byte(8'h01, a); check("wrap_ack0", 32'(a), 32'd0);
    send_byte(8'h02, a); check("wrap_ack1", 32'(a), 32'd0);
    stop_cond();
    check_counts("wrap");

    // aborted byte, then confirm the pointer is still 0x30
    start_cond();
    send_byte(8'h7C, a);
    send_byte(8'h30, a);
    for (int i = 0; i < 4; i++) clk_bit(1'(i % 2 == 0), a);
    stop_cond();
    check_counts("abort");
    push_re(8'h30);
    start_cond();
    send_byte(8'h7D, a);
    recv_byte(1'b1, d); check("abort_rd_byte", 32'(d), 32'hCF);
    stop_cond();
    check_counts("abort_rd");

    // reset while the target drives a 0 bit of 0xBF
    push_re(8'h40);
    start_cond();
    send_byte(8'h7C, a);
    send_byte(8'h40, a);
    start_cond();
    send_byte(8'h7D, a);
    clk_bit(1'b1, a); check("rr_bit7", 32'(a), 32'd1);
    wait_clk(Q); wait_clk(Q); scl = 1'b1;
    wait_clk(Q); check("rr_bit6_low", 32'(sda_bus), 32'd0);
    rst = 1'b1;
    wait_clk(1);
    check("rr_sda_rel", 32'(sda_bus), 32'd1);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_strobes", 32'({rif.reg_we, rif.reg_re}), 32'd0);
    check("rr_addr_wdata", 32'({rif.reg_addr, rif.reg_wdata}), 32'd0);
    rst = 1'b0;
    wait_clk(Q); scl = 1'b0;
    stop_cond();
    push_we(8'h50, 8'h77);
    start_cond();
    send_byte(8'h7C, a); check("rr_w_ack_addr", 32'(a), 32'd0);
    send_byte(8'h50, a);
    send_byte(8'h77, a); check("rr_w_ack_data", 32'(a), 32'd0);
    stop_cond();
    check_counts("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
